scalar_result_commit: RTL and testbench
=======================================

Name: scalar_result_commit

Overview:
- Receiving end of the scalar ALU result path: consumes ALU `result` / `sign_bits` plus decode side-info through a valid/ready handshake.
- Buffers entries in a small in-order FIFO and resolves branches from the sign code.
- Drives the scalar register-file write port and the fetch PC redirect.
- Sits between the execute stage and writeback/fetch.

Parameters:
- SCALAR_REG_LEN, 64, width of result and write data
- DATA_LEN, 32, width of PC / target addresses
- REG_INDEX_WIDTH, 5, destination register index width
- FIFO_DEPTH, 2, entry count; power of two, >= 2

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has an entry
- in_ready  output  1  block can accept an entry
- in_result  input  SCALAR_REG_LEN  ALU result
- in_sign_bits  input  2  ALU sign code (`POS/`ZERO/`NEG from shared defines)
- in_kind  input  2  00 WRITE, 01 BRANCH, 10 JUMP, 11 reserved (commits as no-op)
- in_branch_cond  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE
- in_rd  input  REG_INDEX_WIDTH  destination register
- in_pc  input  DATA_LEN  instruction PC
- in_target  input  DATA_LEN  branch/jump target
- wb_ready  input  1  register file accepts a write this cycle
- wb_en  output  1  register write strobe (registered)
- wb_rd  output  REG_INDEX_WIDTH  write index (registered)
- wb_data  output  SCALAR_REG_LEN  write data (registered)
- redirect_valid  output  1  fetch redirect strobe (registered)
- redirect_pc  output  DATA_LEN  redirect address (registered)

Behaviour:
- Reset (async, any time including mid-operation):
  - FIFO emptied, state RUN.
  - wb_en=0, wb_rd=0, wb_data=0, redirect_valid=0, redirect_pc=0.
  - in_ready=0 while rst is high.
- Handshake:
  - Enqueue on a rising edge where in_valid && in_ready.
  - in_ready = (state==RUN) && (count<FIFO_DEPTH); no same-cycle bypass, so a full FIFO deasserts in_ready even if the head commits that cycle.
  - in_* fields are sampled only on the accepting edge.
- Commit: the head entry commits on a rising edge when:
  - kind WRITE or JUMP: wb_ready=1;
  - kind BRANCH or reserved: unconditionally.
  - At most one commit per edge. wb_en and redirect_valid are single-cycle pulses, cleared on edges without a commit.
- Latency: an entry accepted on edge k (FIFO previously empty, wb_ready=1) commits on edge k+1; outputs are visible after edge k+1.
- WRITE: wb_en=1 if in_rd!=0, wb_rd=in_rd, wb_data=in_result. For in_rd==0 the entry still commits with wb_en=0.
- BRANCH taken condition:
  - BEQ: sign==`ZERO
  - BNE: sign!=`ZERO
  - BLT: sign==`NEG
  - BGE: sign==`POS or `ZERO
  - any other code: not taken
  - If taken: redirect_valid=1, redirect_pc=in_target. No register write.
- JUMP: redirect_valid=1, redirect_pc=in_target; wb_en=(in_rd!=0), wb_data = zero-extended in_pc+4 (DATA_LEN wrap).
- Flush on redirect:
  - On the edge a redirecting entry commits, all other FIFO entries are discarded.
  - An entry enqueued on that same edge is also discarded.
  - State goes to FLUSH for one cycle (in_ready=0), then returns to RUN.
- Count is maintained with enqueue and commit on the same edge: count unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH.
- Empty FIFO: no commit, outputs pulse low.

Optional Feature:
- Macro: SCALAR_COMMIT_STATS_EN.
- When defined: adds output ports taken_count and commit_count, each 32 bits.
  - Async-reset to 0.
  - commit_count increments on every commit; taken_count on every redirecting commit.
  - Both wrap at 2^32.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then in_valid with WRITE rd=5, result=0x1234, wb_ready=1 -> one-cycle wb_en=1, wb_rd=5, wb_data=0x1234 after the next edge; in_ready=1 throughout.
- WRITE rd=0, result=7 -> commits, wb_en stays 0, FIFO returns empty.
- BRANCH BEQ sign=`ZERO, target=0x40, with a WRITE rd=3 queued behind it -> redirect_valid=1, redirect_pc=0x40; rd=3 write never appears; in_ready=0 for one cycle. Repeat with BLT sign=`POS -> no redirect, rd=3 writes normally.
- JUMP pc=0x100, target=0x200, rd=1 -> redirect_pc=0x200, wb_data=0x104, both strobes on the same edge.
- Hold wb_ready=0, push 2 WRITEs -> in_ready=0 when full; third entry held by producer. Raise wb_ready -> commits in order, one per edge, and the third entry is accepted.
- Assert rst mid-stream with 2 entries queued -> outputs 0 immediately, no stale commits after rst deasserts. With SCALAR_COMMIT_STATS_EN: counters read 0 after reset and match after 3 commits including 1 taken branch (3, 1).

Source files
------------

// File: rtl/scalar_result_commit.sv
// Commit end of the scalar ALU result path: in-order entry FIFO, branch resolution,
// register-file write port and fetch redirect. SCALAR_COMMIT_STATS_EN adds commit/taken counters.
`ifndef POS
`define POS 2'b00
`endif
`ifndef ZERO
`define ZERO 2'b01
`endif
`ifndef NEG
`define NEG 2'b10
`endif

module scalar_result_commit #(
   parameter int unsigned SCALAR_REG_LEN  = 64,
   parameter int unsigned DATA_LEN        = 32,
   parameter int unsigned REG_INDEX_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH      = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SCALAR_REG_LEN-1:0]  in_result,
   input  logic [1:0]                 in_sign_bits,
   input  logic [1:0]                 in_kind,
   input  logic [2:0]                 in_branch_cond,
   input  logic [REG_INDEX_WIDTH-1:0] in_rd,
   input  logic [DATA_LEN-1:0]        in_pc,
   input  logic [DATA_LEN-1:0]        in_target,
   input  logic                       wb_ready,
   output logic                       wb_en,
   output logic [REG_INDEX_WIDTH-1:0] wb_rd,
   output logic [SCALAR_REG_LEN-1:0]  wb_data,
   output logic                       redirect_valid,
`ifdef SCALAR_COMMIT_STATS_EN
   output logic [31:0]                taken_count,
   output logic [31:0]                commit_count,
`endif
   output logic [DATA_LEN-1:0]        redirect_pc
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] KIND_WRITE  = 2'b00;
   localparam logic [1:0] KIND_BRANCH = 2'b01;
   localparam logic [1:0] KIND_JUMP   = 2'b10;

   localparam logic [2:0] COND_BEQ = 3'b000;
   localparam logic [2:0] COND_BNE = 3'b001;
   localparam logic [2:0] COND_BLT = 3'b100;
   localparam logic [2:0] COND_BGE = 3'b101;

   typedef struct packed {
      logic [SCALAR_REG_LEN-1:0]  result;
      logic [1:0]                 sign;
      logic [1:0]                 kind;
      logic [2:0]                 cond;
      logic [REG_INDEX_WIDTH-1:0] rd;
      logic [DATA_LEN-1:0]        pc;
      logic [DATA_LEN-1:0]        target;
   } entry_t;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t             state, next_state;
   entry_t             mem [FIFO_DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count;
   logic               enq, commit, taken, redirect, writes;
   logic [DATA_LEN-1:0] link_pc;

   // Handshake, commit qualification, branch resolution and FSM next state
   always_comb begin
      next_state = state;
      head       = mem[rd_ptr];
      in_ready   = !rst && (state == RUN) && (count < CNT_W'(FIFO_DEPTH));
      enq        = in_valid && in_ready;
      commit     = 1'b0;
      taken      = 1'b0;
      writes     = (head.kind == KIND_WRITE) || (head.kind == KIND_JUMP);
      link_pc    = head.pc + DATA_LEN'(4);

      if (count != '0) commit = writes ? wb_ready : 1'b1;

      case (head.cond)
         COND_BEQ: taken = (head.sign == `ZERO);
         COND_BNE: taken = (head.sign != `ZERO);
         COND_BLT: taken = (head.sign == `NEG);
         COND_BGE: taken = (head.sign == `POS) || (head.sign == `ZERO);
         default:  taken = 1'b0;
      endcase

      redirect = commit && ((head.kind == KIND_JUMP) || ((head.kind == KIND_BRANCH) && taken));

      case (state)
         RUN:     if (redirect) next_state = FLUSH;
         FLUSH:   next_state = RUN;
         default: next_state = RUN;
      endcase
   end

   // Entry storage; payload needs no reset since count gates every read
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= '{result: in_result, sign: in_sign_bits, kind: in_kind,
                                cond: in_branch_cond, rd: in_rd, pc: in_pc, target: in_target};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= RUN;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         wb_en          <= 1'b0;
         wb_rd          <= '0;
         wb_data        <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         state <= next_state;
         // A redirect discards queued entries and anything accepted on the same edge
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (enq)    wr_ptr <= wr_ptr + PTR_W'(1);
            if (commit) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !commit)      count <= count + CNT_W'(1);
            else if (!enq && commit) count <= count - CNT_W'(1);
         end

         wb_en <= commit && writes && (head.rd != '0);
         if (commit && writes) begin
            wb_rd   <= head.rd;
            wb_data <= (head.kind == KIND_JUMP) ? SCALAR_REG_LEN'(link_pc) : head.result;
         end

         redirect_valid <= redirect;
         if (redirect) redirect_pc <= head.target;
      end
   end

`ifdef SCALAR_COMMIT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_count <= '0;
         taken_count  <= '0;
      end else begin
         if (commit)   commit_count <= commit_count + 32'd1;
         if (redirect) taken_count  <= taken_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_scalar_result_commit.sv
// Scoreboard bench for scalar_result_commit: expected strobes queued at stimulus time,
// popped and compared by a negedge monitor whenever wb_en or redirect_valid pulses.
`ifndef POS
`define POS 2'b00
`endif
`ifndef ZERO
`define ZERO 2'b01
`endif
`ifndef NEG
`define NEG 2'b10
`endif

module tb_scalar_result_commit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_result = '0;
   logic [1:0]  in_sign_bits = '0;
   logic [1:0]  in_kind = '0;
   logic [2:0]  in_branch_cond = '0;
   logic [4:0]  in_rd = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_target = '0;
   logic        wb_ready = 1'b1;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef SCALAR_COMMIT_STATS_EN
   logic [31:0] taken_count;
   logic [31:0] commit_count;
`endif

   typedef struct {
      logic        wen;
      logic [4:0]  rd;
      logic [63:0] data;
      logic        rv;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   failed   = 0;

   scalar_result_commit dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_sign_bits(in_sign_bits), .in_kind(in_kind),
      .in_branch_cond(in_branch_cond), .in_rd(in_rd), .in_pc(in_pc), .in_target(in_target),
      .wb_ready(wb_ready),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .redirect_valid(redirect_valid),
`ifdef SCALAR_COMMIT_STATS_EN
      .taken_count(taken_count), .commit_count(commit_count),
`endif
      .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   // Every observed strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && (wb_en || redirect_valid)) begin
         compared++;
         if (sb.size() == 0) begin
            failed++;
            $display("FAIL unexpected_commit: got wb_en=%0b rd=%0d data=%h redir=%0b pc=%h, required no strobe",
                     wb_en, wb_rd, wb_data, redirect_valid, redirect_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (wb_en !== e.wen || redirect_valid !== e.rv ||
                (e.wen && (wb_rd !== e.rd || wb_data !== e.data)) ||
                (e.rv && redirect_pc !== e.pc)) begin
               failed++;
               $display("FAIL commit_event: got wb_en=%0b rd=%0d data=%h redir=%0b pc=%h, required wb_en=%0b rd=%0d data=%h redir=%0b pc=%h",
                        wb_en, wb_rd, wb_data, redirect_valid, redirect_pc, e.wen, e.rd, e.data, e.rv, e.pc);
            end
         end
      end
   end

   task automatic expect_ev(input logic wen, input logic [4:0] rd, input logic [63:0] data,
                            input logic rv, input logic [31:0] pc);
      exp_t e;
      e.wen = wen; e.rd = rd; e.data = data; e.rv = rv; e.pc = pc;
      sb.push_back(e);
   endtask

   task automatic set_entry(input logic [1:0] kind, input logic [2:0] cond, input logic [1:0] sign,
                            input logic [4:0] rd, input logic [63:0] result,
                            input logic [31:0] pc, input logic [31:0] target);
      in_valid = 1'b1; in_kind = kind; in_branch_cond = cond; in_sign_bits = sign;
      in_rd = rd; in_result = result; in_pc = pc; in_target = target;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic wait_accept(input string name);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         compared++; failed++;
         $display("FAIL accept_timeout_%s: in_ready=%0b after %0d cycles, required 1", name, in_ready, n);
         in_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic push(input string name, input logic [1:0] kind, input logic [2:0] cond,
                       input logic [1:0] sign, input logic [4:0] rd, input logic [63:0] result,
                       input logic [31:0] pc, input logic [31:0] target);
      set_entry(kind, cond, sign, rd, result, pc, target);
      wait_accept(name);
   endtask

   task automatic check_drain(input string name);
      repeat (4) @(posedge clk);
      #1;
      compared++;
      if (sb.size() != 0) begin
         failed++;
         $display("FAIL drain_%s: %0d expected commits never seen, required 0", name, sb.size());
         sb.delete();
      end
      compared++;
      if (in_ready !== 1'b1) begin
         failed++;
         $display("FAIL idle_ready_%s: in_ready=%0b, required 1", name, in_ready);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      compared++;
      if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 64'd0 ||
          redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin
         failed++;
         $display("FAIL %s: wb_en=%0b rd=%0d data=%h redir=%0b pc=%h, required all zero",
                  name, wb_en, wb_rd, wb_data, redirect_valid, redirect_pc);
      end
      compared++;
      if (in_ready !== 1'b0) begin
         failed++;
         $display("FAIL %s_ready: in_ready=%0b, required 0", name, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset_outputs");
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      expect_ev(1'b1, 5'd5, 64'h1234, 1'b0, 32'd0);
      push("w5", 2'b00, 3'b000, `POS, 5'd5, 64'h1234, 32'h0, 32'h0);
      compared++;
      if (in_ready !== 1'b1) begin
         failed++;
         $display("FAIL write_ready: in_ready=%0b, required 1", in_ready);
      end
      check_drain("write");
   endtask

   task automatic test_write_r0();
      push("w0", 2'b00, 3'b000, `POS, 5'd0, 64'd7, 32'h0, 32'h0);
      check_drain("write_r0");
   endtask

   task automatic test_branch();
      // Taken BEQ: the write accepted on the redirect edge is discarded
      expect_ev(1'b0, 5'd0, 64'd0, 1'b1, 32'h40);
      push("beq", 2'b01, 3'b000, `ZERO, 5'd0, 64'd0, 32'h10, 32'h40);
      push("w3_flushed", 2'b00, 3'b000, `POS, 5'd3, 64'h33, 32'h14, 32'h0);
      compared++;
      if (in_ready !== 1'b0) begin
         failed++;
         $display("FAIL flush_ready: in_ready=%0b, required 0", in_ready);
      end
      @(posedge clk); #1;
      compared++;
      if (in_ready !== 1'b1) begin
         failed++;
         $display("FAIL post_flush_ready: in_ready=%0b, required 1", in_ready);
      end
      check_drain("beq");
      // Not-taken BLT: following write commits normally
      expect_ev(1'b1, 5'd3, 64'h33, 1'b0, 32'd0);
      push("blt", 2'b01, 3'b100, `POS, 5'd0, 64'd0, 32'h10, 32'h40);
      push("w3", 2'b00, 3'b000, `POS, 5'd3, 64'h33, 32'h14, 32'h0);
      check_drain("blt");
      // BGE on NEG and BNE on ZERO are not taken; reserved kind commits silently
      push("bge_nt", 2'b01, 3'b101, `NEG, 5'd0, 64'd0, 32'h20, 32'h80);
      push("bne_nt", 2'b01, 3'b001, `ZERO, 5'd0, 64'd0, 32'h24, 32'h80);
      push("rsvd", 2'b11, 3'b000, `ZERO, 5'd4, 64'd9, 32'h28, 32'h80);
      check_drain("not_taken");
   endtask

   task automatic test_jump();
      expect_ev(1'b1, 5'd1, 64'h104, 1'b1, 32'h200);
      push("jal", 2'b10, 3'b000, `POS, 5'd1, 64'hdead, 32'h100, 32'h200);
      check_drain("jump");
      expect_ev(1'b1, 5'd2, 64'h3, 1'b1, 32'h300);
      push("jal_wrap", 2'b10, 3'b000, `POS, 5'd2, 64'd0, 32'hffff_ffff, 32'h300);
      check_drain("jump_wrap");
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b0;
      expect_ev(1'b1, 5'd6, 64'h66, 1'b0, 32'd0);
      expect_ev(1'b1, 5'd7, 64'h77, 1'b0, 32'd0);
      expect_ev(1'b1, 5'd8, 64'h88, 1'b0, 32'd0);
      push("a", 2'b00, 3'b000, `POS, 5'd6, 64'h66, 32'h0, 32'h0);
      push("b", 2'b00, 3'b000, `POS, 5'd7, 64'h77, 32'h0, 32'h0);
      set_entry(2'b00, 3'b000, `POS, 5'd8, 64'h88, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         compared++;
         if (in_ready !== 1'b0) begin
            failed++;
            $display("FAIL full_ready_%0d: in_ready=%0b, required 0", i, in_ready);
         end
         @(posedge clk); #1;
      end
      compared++;
      if (sb.size() != 3) begin
         failed++;
         $display("FAIL stalled_commit: %0d pending, required 3", sb.size());
      end
      wb_ready = 1'b1;
      wait_accept("c");
      check_drain("back_to_back");
   endtask

   task automatic test_reset_mid();
      wb_ready = 1'b0;
      push("r9", 2'b00, 3'b000, `POS, 5'd9, 64'h99, 32'h0, 32'h0);
      push("r10", 2'b00, 3'b000, `POS, 5'd10, 64'haa, 32'h0, 32'h0);
      wb_ready = 1'b1;
      @(posedge clk); #1;
      compared++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd9) begin
         failed++;
         $display("FAIL pre_reset_commit: wb_en=%0b rd=%0d, required 1 / 9", wb_en, wb_rd);
      end
      #1 rst = 1'b1;
      #1 check_outputs_zero("mid_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      check_drain("after_reset");
   endtask

`ifdef SCALAR_COMMIT_STATS_EN
   task automatic test_stats();
      compared++;
      if (commit_count !== 32'd0 || taken_count !== 32'd0) begin
         failed++;
         $display("FAIL stats_reset: commit=%0d taken=%0d, required 0 / 0", commit_count, taken_count);
      end
      expect_ev(1'b1, 5'd2, 64'h22, 1'b0, 32'd0);
      expect_ev(1'b0, 5'd0, 64'd0, 1'b1, 32'h80);
      push("s_w2", 2'b00, 3'b000, `POS, 5'd2, 64'h22, 32'h0, 32'h0);
      push("s_bne", 2'b01, 3'b001, `NEG, 5'd0, 64'd0, 32'h4, 32'h80);
      check_drain("stats_a");
      expect_ev(1'b1, 5'd4, 64'h44, 1'b0, 32'd0);
      push("s_w4", 2'b00, 3'b000, `POS, 5'd4, 64'h44, 32'h0, 32'h0);
      check_drain("stats_b");
      compared++;
      if (commit_count !== 32'd3 || taken_count !== 32'd1) begin
         failed++;
         $display("FAIL stats_count: commit=%0d taken=%0d, required 3 / 1", commit_count, taken_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_write_r0();
      test_branch();
      test_jump();
      test_back_to_back();
      test_reset_mid();
`ifdef SCALAR_COMMIT_STATS_EN
      test_stats();
`endif
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
